// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for Mini-MIPS.
//            Optional performance counters under macro SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter logic [5:0]  HALT_OP = 6'd63,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       op_code,
    input  logic [5:0]       func,
    input  logic             instr_valid,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             alu_en,
    output logic             branch_eval,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic             reg_write_en,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_NOWB   = 3'd4,
        CLS_HALT   = 3'd5
    } cls_t;

    localparam logic [5:0] c_OP_SPECIAL = 6'd0;
    localparam logic [5:0] c_OP_LOAD    = 6'd35;
    localparam logic [5:0] c_OP_STORE   = 6'd43;

    state_t r_state;
    state_t w_next;
    cls_t   r_cls;
    cls_t   w_dec_cls;

    if (CNT_W == 0) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Priority-ordered instruction class decode
    always_comb begin
        w_dec_cls = CLS_ALU;
        if (op_code == HALT_OP)
            w_dec_cls = CLS_HALT;
        else if (op_code == c_OP_LOAD)
            w_dec_cls = CLS_LOAD;
        else if (op_code == c_OP_STORE)
            w_dec_cls = CLS_STORE;
        else if (op_code == 6'd41 || (op_code >= 6'd48 && op_code <= 6'd54))
            w_dec_cls = CLS_BRANCH;
        else if (op_code == 6'd1 || op_code == 6'd3 ||
                 (op_code == c_OP_SPECIAL &&
                  (func == 6'd24 || func == 6'd25 || func == 6'd26)))
            w_dec_cls = CLS_NOWB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cls   <= CLS_ALU;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cls <= w_dec_cls;
        end
    end

    always_comb begin
        w_next       = r_state;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        alu_en       = 1'b0;
        branch_eval  = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        busy         = 1'b1;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                ir_write = instr_valid;
                pc_inc   = instr_valid;
                if (instr_valid)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_dec_cls == CLS_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_en      = 1'b1;
                branch_eval = (r_cls == CLS_BRANCH);
                case (r_cls)
                    CLS_LOAD, CLS_STORE: w_next = S_MEM;
                    CLS_ALU:             w_next = S_WB;
                    default:             w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Strobe stays up through the cycle in which mem_ready arrives
                mem_read_en  = (r_cls == CLS_LOAD);
                mem_write_en = (r_cls == CLS_STORE);
                if (mem_ready)
                    w_next = (r_cls == CLS_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write_en = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign state = r_state;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_state == S_DECODE && w_dec_cls != CLS_HALT)
                r_instr_count <= r_instr_count + CNT_W'(1);
            if ((r_state == S_FETCH && !instr_valid) ||
                (r_state == S_MEM && !mem_ready))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Scoreboard bench for multicycle_sequencer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int c_CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] op_code = 6'd0;
    logic [5:0] func = 6'd0;
    logic       instr_valid = 1'b1;
    logic       mem_ready = 1'b1;
    logic       ir_write, pc_inc, alu_en, branch_eval;
    logic       mem_read_en, mem_write_en, reg_write_en, busy, halted;
    logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [c_CNT_W-1:0] instr_count, stall_count;
`endif

    multicycle_sequencer #(.HALT_OP(6'd63), .CNT_W(c_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_code      (op_code),
        .func         (func),
        .instr_valid  (instr_valid),
        .mem_ready    (mem_ready),
        .ir_write     (ir_write),
        .pc_inc       (pc_inc),
        .alu_en       (alu_en),
        .branch_eval  (branch_eval),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .reg_write_en (reg_write_en),
        .busy         (busy),
        .halted       (halted),
        .state        (state)
`ifdef SEQ_PERF_CNT_EN
        ,
        .instr_count  (instr_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Strobe literal layout: {ir_write, pc_inc, alu_en, branch_eval, mem_read_en, mem_write_en, reg_write_en}
    localparam logic [6:0] c_NONE = 7'b0000000;
    localparam logic [6:0] c_FET  = 7'b1100000;
    localparam logic [6:0] c_EXE  = 7'b0010000;
    localparam logic [6:0] c_BRX  = 7'b0011000;
    localparam logic [6:0] c_MRD  = 7'b0000100;
    localparam logic [6:0] c_MWR  = 7'b0000010;
    localparam logic [6:0] c_WB   = 7'b0000001;

    typedef struct {
        string       name;
        logic [11:0] vec;
        bit          chk_cnt;
        int          ic;
        int          sc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // One expected entry per cycle: inputs for this cycle plus the DUT response
    task automatic step(input string nm, input logic r, input logic s,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic iv, input logic mr,
                        input logic [2:0] est, input logic [6:0] estrb,
                        input bit chk = 1'b0, input int eic = 0, input int esc = 0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; start = s; op_code = op; func = fn;
        instr_valid = iv; mem_ready = mr;
        e.name    = nm;
        e.vec     = {est, estrb, (est >= 3'd1 && est <= 3'd5), (est == 3'd6)};
        e.chk_cnt = chk;
        e.ic      = eic;
        e.sc      = esc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [11:0] got;
            e   = exp_q.pop_front();
            got = {state, ir_write, pc_inc, alu_en, branch_eval, mem_read_en,
                   mem_write_en, reg_write_en, busy, halted};
            total++;
            if (got !== e.vec) begin
                bad++;
                $display("FAIL %s: got st=%0d out=%b bz/h=%b, want st=%0d out=%b bz/h=%b",
                         e.name, got[11:9], got[8:2], got[1:0],
                         e.vec[11:9], e.vec[8:2], e.vec[1:0]);
            end
`ifdef SEQ_PERF_CNT_EN
            if (e.chk_cnt) begin
                total++;
                if (instr_count !== c_CNT_W'(e.ic) || stall_count !== c_CNT_W'(e.sc)) begin
                    bad++;
                    $display("FAIL %s_cnt: got ic=%0d sc=%0d, want ic=%0d sc=%0d",
                             e.name, instr_count, stall_count, e.ic, e.sc);
                end
            end
`endif
        end
    end

    initial begin
        // Reset held two cycles
        step("rst0", 1, 0, 6'd35, 6'd0, 1, 1, 3'd0, c_NONE, 1, 0, 0);
        step("rst1", 1, 0, 6'd35, 6'd0, 1, 1, 3'd0, c_NONE);
        // LOAD, zero wait states
        step("ld_idle", 0, 1, 6'd35, 6'd0, 1, 1, 3'd0, c_NONE);
        step("ld_f",    0, 0, 6'd35, 6'd0, 1, 1, 3'd1, c_FET);
        step("ld_d",    0, 0, 6'd35, 6'd0, 1, 1, 3'd2, c_NONE);
        step("ld_e",    0, 0, 6'd35, 6'd0, 1, 1, 3'd3, c_EXE);
        step("ld_m",    0, 0, 6'd35, 6'd0, 1, 1, 3'd4, c_MRD);
        step("ld_w",    0, 0, 6'd35, 6'd0, 1, 1, 3'd5, c_WB);
        // STORE with three memory wait cycles
        step("st_f",    0, 0, 6'd43, 6'd0, 1, 1, 3'd1, c_FET);
        step("st_d",    0, 0, 6'd43, 6'd0, 1, 1, 3'd2, c_NONE);
        step("st_e",    0, 0, 6'd43, 6'd0, 1, 0, 3'd3, c_EXE);
        step("st_m0",   0, 0, 6'd43, 6'd0, 1, 0, 3'd4, c_MWR);
        step("st_m1",   0, 0, 6'd43, 6'd0, 1, 0, 3'd4, c_MWR);
        step("st_m2",   0, 0, 6'd43, 6'd0, 1, 0, 3'd4, c_MWR);
        step("st_m3",   0, 0, 6'd43, 6'd0, 1, 1, 3'd4, c_MWR);
        // BRANCH (op 48), start pulsed while busy
        step("br_f",    0, 0, 6'd48, 6'd0, 1, 1, 3'd1, c_FET, 1, 2, 3);
        step("br_d",    0, 0, 6'd48, 6'd0, 1, 1, 3'd2, c_NONE);
        step("br_e",    0, 1, 6'd48, 6'd0, 1, 1, 3'd3, c_BRX);
        // NOWB (op 0, func 24)
        step("nw_f",    0, 0, 6'd0, 6'd24, 1, 1, 3'd1, c_FET);
        step("nw_d",    0, 0, 6'd0, 6'd24, 1, 1, 3'd2, c_NONE);
        step("nw_e",    0, 0, 6'd0, 6'd24, 1, 1, 3'd3, c_EXE);
        // ALU (op 0, func 32) with two fetch wait cycles
        step("alu_f0",  0, 0, 6'd0, 6'd32, 0, 1, 3'd1, c_NONE);
        step("alu_f1",  0, 0, 6'd0, 6'd32, 0, 1, 3'd1, c_NONE);
        step("alu_f2",  0, 0, 6'd0, 6'd32, 1, 1, 3'd1, c_FET);
        step("alu_d",   0, 0, 6'd0, 6'd32, 1, 1, 3'd2, c_NONE);
        step("alu_e",   0, 0, 6'd0, 6'd32, 1, 1, 3'd3, c_EXE);
        step("alu_w",   0, 0, 6'd0, 6'd32, 1, 1, 3'd5, c_WB);
        // HALT, start ignored, reset returns to IDLE
        step("h_f",     0, 0, 6'd63, 6'd0, 1, 1, 3'd1, c_FET, 1, 5, 5);
        step("h_d",     0, 0, 6'd63, 6'd0, 1, 1, 3'd2, c_NONE);
        step("h_h0",    0, 1, 6'd63, 6'd0, 1, 1, 3'd6, c_NONE, 1, 5, 5);
        step("h_h1",    0, 0, 6'd63, 6'd0, 1, 1, 3'd6, c_NONE);
        step("h_h2",    0, 1, 6'd63, 6'd0, 1, 1, 3'd6, c_NONE);
        step("h_h3",    1, 0, 6'd63, 6'd0, 1, 1, 3'd6, c_NONE, 1, 5, 5);
        step("h_idle",  0, 0, 6'd35, 6'd0, 1, 1, 3'd0, c_NONE, 1, 0, 0);
        // Reset in MEM of a LOAD aborts it
        step("ab_idle", 0, 1, 6'd35, 6'd0, 1, 1, 3'd0, c_NONE);
        step("ab_f",    0, 0, 6'd35, 6'd0, 1, 1, 3'd1, c_FET);
        step("ab_d",    0, 0, 6'd35, 6'd0, 1, 0, 3'd2, c_NONE);
        step("ab_e",    0, 0, 6'd35, 6'd0, 1, 0, 3'd3, c_EXE);
        step("ab_m",    1, 0, 6'd35, 6'd0, 1, 0, 3'd4, c_MRD);
        step("ab_rst",  0, 0, 6'd3,  6'd0, 1, 1, 3'd0, c_NONE, 1, 0, 0);
        // Fresh start afterwards runs a NOWB (op 3)
        step("re_idle", 0, 1, 6'd3, 6'd0, 1, 1, 3'd0, c_NONE);
        step("re_f",    0, 0, 6'd3, 6'd0, 1, 1, 3'd1, c_FET);
        step("re_d",    0, 0, 6'd3, 6'd0, 1, 1, 3'd2, c_NONE);
        step("re_e",    0, 0, 6'd3, 6'd0, 0, 1, 3'd3, c_EXE);
        step("re_f2",   0, 0, 6'd3, 6'd0, 0, 1, 3'd1, c_NONE);
        @(posedge clk);
        @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the Mini-MIPS datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- It emits one-cycle phase enables that qualify the static control signals produced by the decode logic (reg_write, mem_read, mem_write, branch).
- It also handles the instruction-memory and data-memory ready handshakes, and a HALT opcode.

Parameters:
- HALT_OP, 6'd63, op_code that parks the FSM in HALT.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE.
- op_code  input  6  opcode from the instruction register, sampled in DECODE.
- func  input  6  function field, sampled in DECODE.
- instr_valid  input  1  instruction memory has data this cycle.
- mem_ready  input  1  data memory has completed the access this cycle.
- ir_write  output  1  load the instruction register.
- pc_inc  output  1  PC <= PC+4.
- alu_en  output  1  ALU result register capture.
- branch_eval  output  1  branch/PC-target update window.
- mem_read_en  output  1  data memory read strobe.
- mem_write_en  output  1  data memory write strobe.
- reg_write_en  output  1  register-file write strobe.
- busy  output  1  FSM is not in IDLE or HALT.
- halted  output  1  FSM is in HALT.
- state  output  3  encoded state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; the latched class register is cleared to ALU.
  - Reset applied mid-instruction aborts it. No strobe is asserted in the following cycle.
- Outputs are Moore decodes of the state register, gated only by the ready inputs as listed below. No output is registered separately.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH:
  - ir_write = pc_inc = instr_valid.
  - instr_valid=1 -> DECODE. Otherwise wait, with no limit.
- DECODE:
  - Latch the class from op_code/func. Priority order is:
    1. HALT: op_code==HALT_OP.
    2. LOAD: op_code==35.
    3. STORE: op_code==43.
    4. BRANCH: op_code==41, or 48 <= op_code <= 54.
    5. NOWB: op_code==1, op_code==3, or op_code==0 with func in {24,25,26}.
    6. ALU: everything else.
  - HALT class -> HALT. All other classes -> EXEC.
- EXEC:
  - alu_en=1. branch_eval=1 only for class BRANCH.
  - Next state by class: LOAD or STORE -> MEM; BRANCH or NOWB -> FETCH; ALU -> WB.
- MEM:
  - LOAD: mem_read_en=1. STORE: mem_write_en=1.
  - The strobe is held every cycle until mem_ready=1.
  - On mem_ready=1: LOAD -> WB, STORE -> FETCH.
  - A mem_ready asserted in any other state is ignored.
- WB: reg_write_en=1 for exactly one cycle, then -> FETCH.
- HALT:
  - halted=1, busy=0. Stay until rst; start is ignored.
- Instruction latency with zero wait states:
  - LOAD 5 cycles (F,D,E,M,W); STORE 4; ALU 4 (F,D,E,W); BRANCH and NOWB 3.
  - Each wait cycle adds 1 cycle.
- Invariants:
  - At most one of ir_write, alu_en, mem_read_en, mem_write_en, reg_write_en is high in any cycle.
  - start while busy is ignored.
  - op_code and func are only sampled in DECODE.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- When defined, two outputs are added:
  - instr_count [CNT_W-1:0]: increments on each DECODE that is not class HALT.
  - stall_count [CNT_W-1:0]: increments on each FETCH cycle with instr_valid=0 and each MEM cycle with mem_ready=0.
- Both counters reset to 0 on rst, wrap modulo 2^CNT_W, and freeze in HALT.
- When undefined, neither port nor counter exists and the rest of the behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then start; instr_valid=1, mem_ready=1 always; op_code=35 -> state sequence 1,2,3,4,5,1. mem_read_en high exactly 1 cycle, reg_write_en high exactly 1 cycle, 5 cycles per instruction.
- op_code=43, mem_ready held low 3 cycles -> mem_write_en high 4 consecutive cycles, then FETCH. reg_write_en never asserted. With SEQ_PERF_CNT_EN, stall_count=3.
- op_code=48, then op_code=0 with func=24 -> each takes 3 cycles. branch_eval=1 only in the EXEC of the first instruction. reg_write_en stays 0 throughout.
- op_code=0, func=32, with instr_valid low 2 cycles in FETCH -> ir_write/pc_inc asserted only in the cycle instr_valid=1. WB follows EXEC, and the instruction takes 6 cycles in total.
- op_code=63 -> HALT after DECODE with halted=1, busy=0. Later start pulses are ignored. rst=1 -> IDLE with all outputs 0.
- rst asserted while in MEM with mem_read_en=1 -> next cycle state=0 and all strobes 0. A new start runs a fresh FETCH.
